// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encoding and flag bundle for the registered ALU
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_PASS = 2'b10,
    OP_LDR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
    logic leq;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = '0;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational adder, optional clamp (ALU_SAT_EN) and flag generation
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [WIDTH-1:0] r_in,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  alu_op_e          op_e;
  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             vflag;

  assign op_e     = alu_op_e'(op);
  assign is_sub   = (op_e == OP_SUB);
  assign is_arith = (op_e == OP_ADD) || (op_e == OP_SUB);

  // SUB is bus_in + ~R + 1: invert R and feed the carry-in
  assign b_eff = is_sub ? ~r_in : r_in;
  assign sum   = {1'b0, bus_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  // Overflow only when both adder inputs share a sign the sum does not
  assign ovf = (bus_in[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus_in[WIDTH-1]);

  // Select the result per op; PASS/LDR forward the bus with C/V cleared
  always_comb begin
    res   = bus_in;
    carry = 1'b0;
    vflag = 1'b0;
    if (is_arith) begin
      res   = sum[WIDTH-1:0];
      carry = sum[WIDTH];
      vflag = ovf;
`ifdef ALU_SAT_EN
      // On overflow the true sign equals the common operand sign
      if (ovf) begin
        res = bus_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
    end
  end

  assign result    = res;
  assign flags.n   = res[WIDTH-1];
  assign flags.z   = (res == '0);
  assign flags.c   = carry;
  assign flags.v   = vflag;
  assign flags.leq = res[WIDTH-1] | (res == '0);

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with R register and valid/ready output stage; clamp under ALU_SAT_EN
module alu_pipe
  import alu_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] R_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] bus_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_leq,
  output logic [WIDTH-1:0] r_value
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic             valid_q;
  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  logic             accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op),
    .bus_in (bus_in),
    .r_in   (r_q),
    .result (core_result),
    .flags  (core_flags)
  );

  // Single output slot: free when empty or being drained this cycle
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register and R update; drain and accept together reload the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= FLAGS_CLEAR;
      r_q      <= R_RESET;
    end else if (accept) begin
      valid_q  <= 1'b1;
      result_q <= core_result;
      flags_q  <= core_flags;
      if (alu_op_e'(op) == OP_LDR) begin
        r_q <= bus_in;
      end
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign flag_n    = flags_q.n;
  assign flag_z    = flags_q.z;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign flag_leq  = flags_q.leq;
  assign r_value   = r_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe, expectations follow ALU_SAT_EN
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] bus_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_n, flag_z, flag_c, flag_v, flag_leq;
  logic [15:0] r_value;

  logic        in_valid8;
  logic        in_ready8;
  logic [1:0]  op8;
  logic [7:0]  bus8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  result8;
  logic        n8, z8, c8, v8, leq8;
  logic [7:0]  r_value8;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [20:0] sb[$];

  alu_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .bus_in(bus_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v), .flag_leq(flag_leq), .r_value(r_value)
  );

  alu_pipe #(.WIDTH(8), .R_RESET(8'h3C)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .bus_in(bus8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .flag_n(n8), .flag_z(z8), .flag_c(c8),
    .flag_v(v8), .flag_leq(leq8), .r_value(r_value8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] ex(input logic [15:0] r, input logic n, input logic z,
                                     input logic c, input logic v, input logic leq);
    return {r, n, z, c, v, leq};
  endfunction

  // Monitor: every handshake completion pops one expected response
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {11'd0, result, flag_n, flag_z, flag_c, flag_v, flag_leq}, 32'hFFFF_FFFF);
      end else begin
        check("scoreboard", {11'd0, result, flag_n, flag_z, flag_c, flag_v, flag_leq}, {11'd0, sb.pop_front()});
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [15:0] b, input logic [20:0] exp);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    op       = o;
    bus_in   = b;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        done = 1;
      end
    end
    if (!done) begin
      check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op       = 'x;
    bus_in   = 'x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; bus_in = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; op8 = '0; bus8 = '0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {flag_n, flag_z, flag_c, flag_v, flag_leq}, 0);
    check("rst_r", r_value, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_r8", r_value8, 8'h3C);
    @(posedge clk); #1;

    send(OP_LDR, 16'h0005, ex(16'h0005, 0, 0, 0, 0, 0));
    send(OP_SUB, 16'h0003, ex(16'hFFFE, 1, 0, 0, 0, 1));
    check("sub_latency_valid", out_valid, 1);
    check("sub_latency_result", result, 16'hFFFE);
    check("r_after_ldr", r_value, 16'h0005);

    send(OP_LDR, 16'h0003, ex(16'h0003, 0, 0, 0, 0, 0));
    send(OP_ADD, 16'hFFFD, ex(16'h0000, 0, 1, 1, 0, 1));

    send(OP_LDR, 16'h0001, ex(16'h0001, 0, 0, 0, 0, 0));
`ifdef ALU_SAT_EN
    send(OP_ADD, 16'h7FFF, ex(16'h7FFF, 0, 0, 0, 1, 0));
`else
    send(OP_ADD, 16'h7FFF, ex(16'h8000, 1, 0, 0, 1, 1));
`endif
    send(OP_PASS, 16'h1234, ex(16'h1234, 0, 0, 0, 0, 0));
    check("r_after_pass", r_value, 16'h0001);
    idle();

    out_ready = 1'b0;
    send(OP_PASS, 16'h00AA, ex(16'h00AA, 0, 0, 0, 0, 0));
    in_valid = 1'b1; op = OP_SUB; bus_in = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, 16'h00AA);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_SUB, 16'h0002, ex(16'h0001, 0, 0, 1, 0, 0));
    idle();

    t0 = cyc;
    send(OP_LDR, 16'h0010, ex(16'h0010, 0, 0, 0, 0, 0));
    send(OP_SUB, 16'h0010, ex(16'h0000, 0, 1, 1, 0, 1));
    send(OP_ADD, 16'h0001, ex(16'h0011, 0, 0, 0, 0, 0));
    send(OP_PASS, 16'h8000, ex(16'h8000, 1, 0, 0, 0, 1));
    check("stream_cycles", cyc - t0, 4);
    idle();

    in_valid8 = 1'b1; op8 = OP_LDR; bus8 = 8'h80;
    @(posedge clk); #1;
    check("w8_r_after_ldr", r_value8, 8'h80);
    op8 = OP_SUB; bus8 = 8'h00;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("w8_valid", out_valid8, 1);
`ifdef ALU_SAT_EN
    check("w8_result", {result8, n8, z8, c8, v8, leq8}, {8'h7F, 5'b00010});
`else
    check("w8_result", {result8, n8, z8, c8, v8, leq8}, {8'h80, 5'b10011});
`endif

    out_ready = 1'b0;
    send(OP_PASS, 16'h5555, ex(16'h5555, 0, 0, 0, 0, 0));
    idle();
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_r", r_value, 0);
    check("midrst_r8", r_value8, 8'h3C);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_replay", out_valid, 0);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
